// File: rtl/smem_pkg.sv
// ---------------------------------------------------------------------------
// smem_pkg
// Shared constants, per-core FSM state encoding and address helpers for the
// shared-memory access controller (smem_access_ctrl and its sub-modules).
// No ports; imported by the interface, smem_core_ctrl and smem_access_ctrl.
// ---------------------------------------------------------------------------
package smem_pkg;

  localparam int NCORES = 16;
  localparam int NBANKS = 16;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int BANK_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } core_state_t;

  // The bank number lives in the top nibble of a core address.
  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: BANK_W];
  endfunction

endpackage

// File: rtl/smem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// smem_access_ctrl_if
// Bundles the core-side request/response bus and the bank-side strobe/finish
// bus of smem_access_ctrl.
//   slave  modport : the controller (takes core requests and bank finishes,
//                    drives responses, strobes and latched address/data)
//   master modport : the environment (cores + bank arbiters)
// Signals (16 cores, 16 banks):
//   core_req/core_we [16], core_addr [192], core_wdata [128]
//   core_rdata [128], core_done/core_busy [16]
//   read/write [16], addr_out [192], data_out [128]
//   bank_finish [256] (bit 16b+c), bank_rdata [2048] (bank b at 128b)
//   core_err [16] exists only when SMEM_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
interface smem_access_ctrl_if;
  import smem_pkg::*;

  logic [NCORES-1:0]               core_req;
  logic [NCORES-1:0]               core_we;
  logic [NCORES*ADDR_W-1:0]        core_addr;
  logic [NCORES*DATA_W-1:0]        core_wdata;
  logic [NCORES*DATA_W-1:0]        core_rdata;
  logic [NCORES-1:0]               core_done;
  logic [NCORES-1:0]               core_busy;
  logic [NCORES-1:0]               read;
  logic [NCORES-1:0]               write;
  logic [NCORES*ADDR_W-1:0]        addr_out;
  logic [NCORES*DATA_W-1:0]        data_out;
  logic [NBANKS*NCORES-1:0]        bank_finish;
  logic [NBANKS*NCORES*DATA_W-1:0] bank_rdata;
`ifdef SMEM_TIMEOUT_EN
  logic [NCORES-1:0]               core_err;
`endif

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, bank_finish, bank_rdata,
    output core_rdata, core_done, core_busy, read, write, addr_out, data_out
`ifdef SMEM_TIMEOUT_EN
    , output core_err
`endif
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, bank_finish, bank_rdata,
    input  core_rdata, core_done, core_busy, read, write, addr_out, data_out
`ifdef SMEM_TIMEOUT_EN
    , input core_err
`endif
  );

endinterface

// File: rtl/smem_core_ctrl.sv
// ---------------------------------------------------------------------------
// smem_core_ctrl
// One core's access FSM (IDLE -> ISSUE -> DONE -> IDLE) with its latched
// address, write data and direction. All outputs are registered.
// Ports:
//   clock, reset      : posedge clock, synchronous active-high reset
//   req, we, addr,    : core request (level), direction, address, write data
//   wdata
//   bank_finish       : finish bit for this core from every bank
//   bank_rdata        : read data slice for this core from every bank
//   rdata, done, busy : returned data, one-cycle completion, access in flight
//   read, write       : strobes, high only during ISSUE
//   addr_out,data_out : latched address / write data
//   err               : timeout flag, pulses with done (SMEM_TIMEOUT_EN only)
// Optional feature macro: SMEM_TIMEOUT_EN (wait counter and err output).
// ---------------------------------------------------------------------------
module smem_core_ctrl
  import smem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [NBANKS-1:0]             bank_finish,
  input  logic [NBANKS-1:0][DATA_W-1:0] bank_rdata,
  output logic [DATA_W-1:0]             rdata,
  output logic                          done,
  output logic                          busy,
  output logic                          read,
  output logic                          write,
  output logic [ADDR_W-1:0]             addr_out,
  output logic [DATA_W-1:0]             data_out
`ifdef SMEM_TIMEOUT_EN
  ,
  output logic                          err
`endif
);

  // The wait counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("smem_core_ctrl: TIMEOUT_CYCLES must be in 2..256");
  end

  core_state_t             state;
  logic                    we_q;
  logic [BANK_W-1:0]       cur_bank;
  logic                    finish_hit;
  logic [DATA_W-1:0]       hit_data;

  // Only the bank named by the latched address may complete this access.
  assign cur_bank   = bank_of(addr_out);
  assign finish_hit = bank_finish[cur_bank];
  assign hit_data   = bank_rdata[cur_bank];

`ifdef SMEM_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      rdata    <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      read     <= 1'b0;
      write    <= 1'b0;
      addr_out <= '0;
      data_out <= '0;
`ifdef SMEM_TIMEOUT_EN
      wait_cnt <= '0;
      err      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SMEM_TIMEOUT_EN
      err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            addr_out <= addr;
            data_out <= wdata;
            we_q     <= we;
            read     <= ~we;
            write    <= we;
            busy     <= 1'b1;
`ifdef SMEM_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          // A real finish takes priority over a timeout in the same cycle.
          if (finish_hit) begin
            if (!we_q) rdata <= hit_data;
            read  <= 1'b0;
            write <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
`ifdef SMEM_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            rdata <= '0;
            read  <= 1'b0;
            write <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        DONE: begin
          // Requests seen here are dropped; the next accept is from IDLE.
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/smem_access_ctrl.sv
// ---------------------------------------------------------------------------
// smem_access_ctrl
// Shared-memory access controller: 16 independent per-core FSMs
// (smem_core_ctrl). This level only slices the packed buses per core.
// Ports:
//   clock, reset : posedge clock, synchronous active-high reset
//   bus          : smem_access_ctrl_if.slave (core requests/responses,
//                  bank strobes, latched address/data, bank finish/rdata)
// Parameters: NCORES (must be 16), TIMEOUT_CYCLES (used with the timeout).
// Optional feature macro: SMEM_TIMEOUT_EN (per-core timeout, bus.core_err).
// ---------------------------------------------------------------------------
module smem_access_ctrl #(
  parameter int NCORES         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clock,
  input  logic                reset,
  smem_access_ctrl_if.slave   bus
);
  import smem_pkg::*;

  if (NCORES != 16) begin : g_bad_ncores
    $error("smem_access_ctrl: only NCORES = 16 is supported");
  end

  for (genvar c = 0; c < NCORES; c++) begin : g_core
    logic [NBANKS-1:0]             fin;
    logic [NBANKS-1:0][DATA_W-1:0] rdat;

    // Gather this core's finish bit and read slice from every bank bus.
    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      assign fin[b]  = bus.bank_finish[NCORES*b + c];
      assign rdat[b] = bus.bank_rdata[NCORES*DATA_W*b + DATA_W*c +: DATA_W];
    end

    smem_core_ctrl #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_core (
      .clock       (clock),
      .reset       (reset),
      .req         (bus.core_req[c]),
      .we          (bus.core_we[c]),
      .addr        (bus.core_addr[ADDR_W*c +: ADDR_W]),
      .wdata       (bus.core_wdata[DATA_W*c +: DATA_W]),
      .bank_finish (fin),
      .bank_rdata  (rdat),
      .rdata       (bus.core_rdata[DATA_W*c +: DATA_W]),
      .done        (bus.core_done[c]),
      .busy        (bus.core_busy[c]),
      .read        (bus.read[c]),
      .write       (bus.write[c]),
      .addr_out    (bus.addr_out[ADDR_W*c +: ADDR_W]),
      .data_out    (bus.data_out[DATA_W*c +: DATA_W])
`ifdef SMEM_TIMEOUT_EN
      ,
      .err         (bus.core_err[c])
`endif
    );
  end

endmodule

// File: tb/tb_smem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_smem_access_ctrl
// Self-checking bench for smem_access_ctrl: directed scenarios followed by a
// randomized run, all compared against a behavioural per-core access model.
// Built with TIMEOUT_CYCLES = 8; timeout scenarios need SMEM_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_smem_access_ctrl;
  import smem_pkg::*;

  localparam int TO = 8;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  smem_access_ctrl_if bus ();

  smem_access_ctrl #(
    .NCORES         (16),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: per core, is an access outstanding, is this its
  // completion cycle, and the latched request fields.
  bit          m_busy  [16];
  bit          m_done  [16];
  bit          m_err   [16];
  bit          m_we    [16];
  logic [11:0] m_addr  [16];
  logic [7:0]  m_wdata [16];
  logic [7:0]  m_rdata [16];
  int          m_wait  [16];

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    for (int c = 0; c < 16; c++) begin
      int bank;
      bank = int'(m_addr[c][11:8]);
      if (reset) begin
        m_busy[c] = 0; m_done[c] = 0; m_err[c] = 0; m_we[c] = 0;
        m_addr[c] = '0; m_wdata[c] = '0; m_rdata[c] = '0; m_wait[c] = 0;
      end else if (m_done[c]) begin
        m_done[c] = 0; m_busy[c] = 0; m_err[c] = 0;
      end else if (!m_busy[c]) begin
        if (bus.core_req[c]) begin
          m_busy[c]  = 1;
          m_we[c]    = bus.core_we[c];
          m_addr[c]  = bus.core_addr[12*c +: 12];
          m_wdata[c] = bus.core_wdata[8*c +: 8];
          m_wait[c]  = 0;
        end
      end else if (bus.bank_finish[16*bank + c]) begin
        if (!m_we[c]) m_rdata[c] = bus.bank_rdata[128*bank + 8*c +: 8];
        m_done[c] = 1;
        m_err[c]  = 0;
      end
`ifdef SMEM_TIMEOUT_EN
      else if (m_wait[c] == TO - 1) begin
        m_rdata[c] = '0;
        m_done[c]  = 1;
        m_err[c]   = 1;
      end else begin
        m_wait[c]++;
      end
`endif
    end
  endtask

  task automatic check_output(input string tag);
    logic [15:0]  e_done, e_busy, e_read, e_write, e_err;
    logic [191:0] e_addr;
    logic [127:0] e_data, e_rdata;
    for (int c = 0; c < 16; c++) begin
      e_done[c]         = m_done[c];
      e_busy[c]         = m_busy[c];
      e_read[c]         = m_busy[c] && !m_done[c] && !m_we[c];
      e_write[c]        = m_busy[c] && !m_done[c] && m_we[c];
      e_err[c]          = m_done[c] && m_err[c];
      e_addr[12*c +: 12] = m_addr[c];
      e_data[8*c +: 8]   = m_wdata[c];
      e_rdata[8*c +: 8]  = m_rdata[c];
    end
    check({tag, "_done"},  192'(bus.core_done),  192'(e_done));
    check({tag, "_busy"},  192'(bus.core_busy),  192'(e_busy));
    check({tag, "_read"},  192'(bus.read),       192'(e_read));
    check({tag, "_write"}, 192'(bus.write),      192'(e_write));
    check({tag, "_addr"},  bus.addr_out,         e_addr);
    check({tag, "_data"},  192'(bus.data_out),   192'(e_data));
    check({tag, "_rdata"}, 192'(bus.core_rdata), 192'(e_rdata));
`ifdef SMEM_TIMEOUT_EN
    check({tag, "_err"},   192'(bus.core_err),   192'(e_err));
`endif
  endtask

  // One clock: model sees the driven inputs, DUT clocks, outputs compared #1 later.
  task automatic apply_stimulus(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    check_output(tag);
  endtask

  task automatic set_req(input int c, input bit we, input logic [11:0] a, input logic [7:0] d);
    bus.core_req[c]          = 1'b1;
    bus.core_we[c]           = we;
    bus.core_addr[12*c +: 12] = a;
    bus.core_wdata[8*c +: 8]  = d;
  endtask

  task automatic set_finish(input int c, input int bank, input logic [7:0] d);
    bus.bank_finish[16*bank + c]         = 1'b1;
    bus.bank_rdata[128*bank + 8*c +: 8] = d;
  endtask

  initial begin
    reset           = 1'b1;
    bus.core_req    = '0;
    bus.core_we     = '0;
    bus.core_addr   = '0;
    bus.core_wdata  = '0;
    bus.bank_finish = '0;
    bus.bank_rdata  = '0;

    // Reset state
    apply_stimulus("rst");
    apply_stimulus("rst");
    check("rst_done_zero", 192'(bus.core_done), 192'(0));
    check("rst_busy_zero", 192'(bus.core_busy), 192'(0));
    reset = 1'b0;

    // Read: core 3 reads 0x512 from bank 5
    set_req(3, 1'b0, 12'h512, 8'h00);
    apply_stimulus("rd_acc");
    bus.core_req = '0;
    check("rd_strobe", 192'(bus.read[3]), 192'(1));
    check("rd_addr", 192'(bus.addr_out[36 +: 12]), 192'(12'h512));
    set_finish(3, 5, 8'hA7);
    apply_stimulus("rd_fin");
    bus.bank_finish = '0;
    check("rd_data", 192'(bus.core_rdata[24 +: 8]), 192'(8'hA7));
    check("rd_done", 192'(bus.core_done[3]), 192'(1));
    check("rd_strobe_drop", 192'(bus.read[3]), 192'(0));
    apply_stimulus("rd_idle");
    check("rd_done_one_cycle", 192'(bus.core_done[3]), 192'(0));

    // Wrong bank: core 0 writes 0x3C to 0x0F1 (bank 0)
    set_req(0, 1'b1, 12'h0F1, 8'h3C);
    apply_stimulus("wb_acc");
    bus.core_req = '0;
    check("wb_write", 192'(bus.write[0]), 192'(1));
    check("wb_data_out", 192'(bus.data_out[7:0]), 192'(8'h3C));
    set_finish(0, 2, 8'h11);
    apply_stimulus("wb_wrong");
    bus.bank_finish = '0;
    check("wb_no_done", 192'(bus.core_done[0]), 192'(0));
    check("wb_still_write", 192'(bus.write[0]), 192'(1));
    set_finish(0, 0, 8'h55);
    apply_stimulus("wb_fin");
    bus.bank_finish = '0;
    check("wb_done", 192'(bus.core_done[0]), 192'(1));
    check("wb_write_drop", 192'(bus.write[0]), 192'(0));
    check("wb_rdata_kept", 192'(bus.core_rdata[7:0]), 192'(8'h00));
    apply_stimulus("wb_idle");

    // Concurrency: all cores read, distinct banks, staggered finishes
    for (int c = 0; c < 16; c++)
      set_req(c, 1'b0, 12'(((c + 3) % 16) * 256 + c), 8'h00);
    apply_stimulus("cc_acc");
    bus.core_req = '0;
    check("cc_all_busy", 192'(bus.core_busy), 192'(16'hFFFF));
    for (int k = 0; k < 14; k++) begin
      set_finish(k, (k + 3) % 16, 8'(k * 7 + 1));
      apply_stimulus("cc_fin");
      bus.bank_finish = '0;
      check("cc_done_k", 192'(bus.core_done), 192'(16'(1 << k)));
    end
    set_finish(14, 1, 8'hE1);
    set_finish(15, 2, 8'hF2);
    apply_stimulus("cc_pair");
    bus.bank_finish = '0;
    check("cc_done_pair", 192'(bus.core_done), 192'(16'hC000));
    apply_stimulus("cc_idle");

    // Busy: core 7 re-requests during ISSUE and DONE
    set_req(7, 1'b0, 12'h2A0, 8'h00);
    apply_stimulus("bz_acc");
    set_req(7, 1'b1, 12'h9FF, 8'hEE);
    apply_stimulus("bz_hold1");
    apply_stimulus("bz_hold2");
    check("bz_addr_kept", 192'(bus.addr_out[84 +: 12]), 192'(12'h2A0));
    set_finish(7, 2, 8'h77);
    apply_stimulus("bz_fin");
    bus.bank_finish = '0;
    check("bz_done", 192'(bus.core_done[7]), 192'(1));
    apply_stimulus("bz_ign");
    bus.core_req = '0;
    check("bz_single_done", 192'(bus.core_done[7]), 192'(0));
    check("bz_not_busy", 192'(bus.core_busy[7]), 192'(0));
    apply_stimulus("bz_idle");

    // Reset during ISSUE, then a request right after reset
    set_req(9, 1'b0, 12'h4C4, 8'h00);
    apply_stimulus("rs_acc");
    bus.core_req = '0;
    check("rs_busy", 192'(bus.core_busy[9]), 192'(1));
    reset = 1'b1;
    apply_stimulus("rs_rst");
    check("rs_rdata_zero", 192'(bus.core_rdata), 192'(0));
    check("rs_addr_zero", bus.addr_out, 192'(0));
    check("rs_busy_zero", 192'(bus.core_busy), 192'(0));
    reset = 1'b0;
    set_req(4, 1'b0, 12'h123, 8'h00);
    apply_stimulus("rs_first");
    bus.core_req = '0;
    check("rs_first_accept", 192'(bus.read[4]), 192'(1));
    set_finish(4, 1, 8'h9B);
    apply_stimulus("rs_fin");
    bus.bank_finish = '0;
    check("rs_done4", 192'(bus.core_done), 192'(16'h0010));
    apply_stimulus("rs_idle");

`ifdef SMEM_TIMEOUT_EN
    // Timeout with no finish: done and err together, rdata forced to 0
    set_req(2, 1'b0, 12'h6AA, 8'h00);
    apply_stimulus("to_acc");
    bus.core_req = '0;
    bus.bank_rdata[128*6 + 16 +: 8] = 8'hC3;
    for (int i = 0; i < TO - 1; i++) begin
      apply_stimulus("to_wait");
      check("to_no_done", 192'(bus.core_done[2]), 192'(0));
    end
    apply_stimulus("to_expire");
    check("to_done", 192'(bus.core_done[2]), 192'(1));
    check("to_err", 192'(bus.core_err[2]), 192'(1));
    check("to_rdata_zero", 192'(bus.core_rdata[16 +: 8]), 192'(0));
    apply_stimulus("to_idle");

    // Finish in the timeout cycle wins
    set_req(2, 1'b0, 12'h6AA, 8'h00);
    apply_stimulus("tf_acc");
    bus.core_req = '0;
    for (int i = 0; i < TO - 1; i++) apply_stimulus("tf_wait");
    set_finish(2, 6, 8'h5A);
    apply_stimulus("tf_fin");
    bus.bank_finish = '0;
    check("tf_done", 192'(bus.core_done[2]), 192'(1));
    check("tf_no_err", 192'(bus.core_err[2]), 192'(0));
    check("tf_rdata", 192'(bus.core_rdata[16 +: 8]), 192'(8'h5A));
    apply_stimulus("tf_idle");
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      for (int c = 0; c < 16; c++) begin
        bus.core_req[c]           = ($urandom_range(0, 2) == 0);
        bus.core_we[c]            = $urandom_range(0, 1) == 1;
        bus.core_addr[12*c +: 12] = 12'($urandom);
        bus.core_wdata[8*c +: 8]  = 8'($urandom);
      end
      for (int w = 0; w < 64; w++) bus.bank_rdata[32*w +: 32] = $urandom;
      bus.bank_finish = '0;
      for (int c = 0; c < 16; c++)
        if (m_busy[c] && !m_done[c] && $urandom_range(0, 2) == 0)
          bus.bank_finish[16*int'(m_addr[c][11:8]) + c] = 1'b1;
      repeat (3) bus.bank_finish[$urandom_range(0, 255)] = 1'b1;
      apply_stimulus("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
